muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - 32-bit iterative multiply/divide unit with HI/LO registers
//
// Purpose: radix-2 sequential MULT/MULTU/DIV/DIVU for a multicycle CPU.
//   Start is accepted in IDLE or DONE. CALC then runs 32 steps on operand
//   magnitudes. FIXUP applies the sign and writes hi/lo. DONE pulses done.
//   MTHI/MTLO writes land only while the unit is not busy.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a, b                operands (rs, rt), latched when start is accepted
//   op                  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   start               request strobe, ignored while busy
//   hi_we, lo_we, wdata MTHI/MTLO write port, ignored while busy or on start
//   hi, lo              result registers
//   busy                high in CALC and FIXUP
//   done                one-cycle completion pulse (DONE state)
//   div_by_zero         high with done for a divide by zero
//
// Configuration: define MULDIV_DIV_EN to build the divide datapath. Without
//   it, DIV/DIVU requests go straight to DONE and leave hi/lo untouched.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] b_q;
  logic        sgn_q;       // signed operation (MULT/DIV)
  logic        neg_prod_q;  // product/quotient must be negated
  logic [63:0] acc;         // {hi part, lo part}; lo half starts as |a|
  logic        dbz_q;

  logic        skip_div;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_fix;
  logic [63:0] step_next;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;
  logic        fix_dbz;

  assign busy        = (state == S_CALC) || (state == S_FIXUP);
  assign done        = (state == S_DONE);
  assign div_by_zero = done & dbz_q;

  assign a_mag_in = (~op[0] && a[31]) ? -a : a;
  assign b_mag    = (sgn_q && b_q[31]) ? -b_q : b_q;

  // Shift-add: add |b| into the upper half when the current multiplier bit
  // (acc[0]) is set, then shift the whole 65-bit value right by one.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  assign prod_fix = neg_prod_q ? -acc : acc;

`ifdef MULDIV_DIV_EN
  logic [31:0] a_q;
  logic        op_div_q;
  logic        neg_a_q;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Restoring step: shift the next dividend bit into the remainder and keep
  // the difference only when it does not borrow. The quotient bit fills the
  // vacated lsb of the low half.
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
  assign div_next  = div_diff[33] ? {div_shift[31:0], acc[30:0], 1'b0}
                                  : {div_diff[31:0], acc[30:0], 1'b1};
  // Truncating division: quotient sign from a^b, remainder sign from a.
  // 0x80000000 / -1 wraps back to 0x80000000 with no special case.
  assign quo_fix   = neg_prod_q ? -acc[31:0]  : acc[31:0];
  assign rem_fix   = neg_a_q    ? -acc[63:32] : acc[63:32];
  assign step_next = op_div_q ? div_next : mul_next;
  assign skip_div  = 1'b0;

  always_comb begin
    fix_hi  = prod_fix[63:32];
    fix_lo  = prod_fix[31:0];
    fix_dbz = 1'b0;
    if (op_div_q) begin
      if (b_q == 32'd0) begin
        fix_hi  = a_q;
        fix_lo  = 32'hFFFF_FFFF;
        fix_dbz = 1'b1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
  end
`else
  assign step_next = mul_next;
  assign fix_hi    = prod_fix[63:32];
  assign fix_lo    = prod_fix[31:0];
  assign fix_dbz   = 1'b0;
  // No divider: a divide request completes immediately with no result.
  assign skip_div  = op[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 5'd0;
      b_q        <= 32'd0;
      sgn_q      <= 1'b0;
      neg_prod_q <= 1'b0;
      acc        <= 64'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      dbz_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
      a_q        <= 32'd0;
      op_div_q   <= 1'b0;
      neg_a_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_CALC: begin
          acc <= step_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIXUP;
        end
        S_FIXUP: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          dbz_q <= fix_dbz;
          state <= S_DONE;
        end
        default: begin  // IDLE or DONE: start wins over MTHI/MTLO
          dbz_q <= 1'b0;
          if (start) begin
            b_q        <= b;
            sgn_q      <= ~op[0];
            neg_prod_q <= ~op[0] & (a[31] ^ b[31]);
            cnt        <= 5'd0;
            acc        <= {32'd0, a_mag_in};
`ifdef MULDIV_DIV_EN
            a_q        <= a;
            op_div_q   <= op[1];
            neg_a_q    <= ~op[0] & a[31];
`endif
            state      <= skip_div ? S_DONE : S_CALC;
          end else begin
            state <= S_IDLE;
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_i, b_i, wdata;
  logic [1:0]  op_i;
  logic        start, hi_we, lo_we;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .a(a_i), .b(b_i), .op(op_i), .start(start),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat;   // edges after the start edge until done is seen
    int          bcy;   // cycles with busy=1
  } exp_t;

  exp_t        scb[$];
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi, m_lo;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] h, input logic [31:0] l, input logic z);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.hi = h; v.lo = l; v.dbz = z;
    return v;
  endfunction

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] p;
    logic signed [63:0] sx, sy, q, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    e.dbz = 1'b0; e.lat = 33; e.bcy = 33;
    e.hi = m_hi; e.lo = m_lo;
    if (!o[1]) begin
      if (o[0]) p = {32'd0, x} * {32'd0, y};
      else      p = sx * sy;
      e.hi = p[63:32]; e.lo = p[31:0];
    end else begin
`ifdef MULDIV_DIV_EN
      if (y == 32'd0) begin
        e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
      end else if (o[0]) begin
        e.lo = x / y; e.hi = x % y;
      end else begin
        q = sx / sy; r = sx % sy;
        e.lo = q[31:0]; e.hi = r[31:0];
      end
`else
      e.lat = 0; e.bcy = 0;
`endif
    end
    return e;
  endfunction

  // Waits for done (n0 busy edges already taken since the start edge) and
  // compares against the oldest scoreboard entry.
  task automatic finish_op(input int n0, input bit chk_pulse);
    exp_t g;
    int n, bc;
    n = n0; bc = n0;
    while (!done && n < 60) begin
      if (busy) bc++;
      step;
      n++;
    end
    g = scb.pop_front();
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 expected=1");
    end else begin
      chk("latency", n, g.lat);
      chk("busy_cycles", bc, g.bcy);
      chk("hi", hi, g.hi);
      chk("lo", lo, g.lo);
      chk("div_by_zero", div_by_zero, g.dbz);
      m_hi = g.hi; m_lo = g.lo;
    end
    if (chk_pulse) begin
      step;
      chk("done_pulse", done, 1'b0);
      chk("dbz_pulse", div_by_zero, 1'b0);
      chk("hi_hold", hi, m_hi);
      chk("lo_hold", lo, m_lo);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input exp_t e, input bit chk_pulse);
    scb.push_back(e);
    op_i = o; a_i = x; b_i = y; start = 1'b1;
    step;
    start = 1'b0;
    finish_op(0, chk_pulse);
  endtask

  initial begin
    exp_t e;
    int   nd;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wdata = 32'd0; a_i = 32'd0; b_i = 32'd0; op_i = 2'd0;
    step; step;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    step;

    tbl.push_back(mk(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
    tbl.push_back(mk(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0));
    tbl.push_back(mk(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0));
    tbl.push_back(mk(2'd1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0));
    tbl.push_back(mk(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0));
    tbl.push_back(mk(2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0));
`ifdef MULDIV_DIV_EN
    tbl.push_back(mk(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
    tbl.push_back(mk(2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1));
    tbl.push_back(mk(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0));
    tbl.push_back(mk(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0));
    tbl.push_back(mk(2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1));
    tbl.push_back(mk(2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0));
`endif
    // Odd entries start straight out of DONE (back-to-back).
    for (int i = 0; i < tbl.size(); i++) begin
      e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.dbz = tbl[i].dbz;
      e.lat = 33; e.bcy = 33;
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, e, (i % 2) == 1);
    end
    step;

    for (int i = 0; i < 4; i++) begin
      logic [31:0] x, y;
      logic [1:0]  o;
      x = $urandom; y = $urandom; o = 2'($urandom_range(0, 1));
      run_op(o, x, y, model(o, x, y), 1'b1);
    end

    // Divide request (absent divider: immediate DONE, hi/lo untouched).
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
    step;
    hi_we = 1'b0; lo_we = 1'b0;
    m_hi = 32'h0BAD_F00D; m_lo = 32'h0BAD_F00D;
    run_op(2'd3, 32'd9, 32'd3, model(2'd3, 32'd9, 32'd3), 1'b1);

    // MTHI preload, then MTLO and a second start while busy are both dropped.
    hi_we = 1'b1; wdata = 32'h1234_5678;
    step;
    hi_we = 1'b0;
    chk("mthi", hi, 32'h1234_5678);
    m_hi = 32'h1234_5678;
    e.hi = 32'd0; e.lo = 32'd12; e.dbz = 1'b0; e.lat = 33; e.bcy = 33;
    scb.push_back(e);
    op_i = 2'd1; a_i = 32'd3; b_i = 32'd4; start = 1'b1;
    step;
    start = 1'b0;
    chk("hi_during_calc", hi, 32'h1234_5678);
    step; step; step; step; step;
    lo_we = 1'b1; wdata = 32'h0000_DEAD;
    op_i = 2'd0; a_i = 32'd100; b_i = 32'd100; start = 1'b1;
    step;
    lo_we = 1'b0; start = 1'b0;
    chk("mtlo_busy_dropped", lo, m_lo);
    finish_op(6, 1'b1);
    nd = 0;
    for (int i = 0; i < 45; i++) begin
      step;
      if (done) nd++;
    end
    chk("no_second_done", nd, 0);

    // start coinciding with MTHI/MTLO in IDLE: writes dropped.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hFFFF_0000;
    scb.push_back(model(2'd0, 32'h0000_0005, 32'hFFFF_FFFE));
    op_i = 2'd0; a_i = 32'h0000_0005; b_i = 32'hFFFF_FFFE; start = 1'b1;
    step;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("collision_hi", hi, m_hi);
    chk("collision_lo", lo, m_lo);
    finish_op(0, 1'b1);

    // Reset at cycle 10 of CALC aborts without a done.
    op_i = 2'd1; a_i = 32'd5; b_i = 32'd6; start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 10; i++) step;
    chk("busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      step;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("scoreboard_empty", scb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
